// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
// State and owner encodings are also used by the core stall logic.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

    // On a tie the requester that did not own the last transaction wins.
    function automatic logic pick_owner(
        input logic core_req,
        input logic dma_req,
        input logic last_owner
    );
        logic sel;
        if (core_req && dma_req) begin
            sel = ~last_owner;
        end else if (core_req) begin
            sel = OWN_CORE;
        end else begin
            sel = OWN_DMA;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// ACCESS-phase watchdog: saturating counter, cleared on grant.
// TIMEOUT = 0 disables expiry.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_on
            assign expired = (cnt == CW'(TIMEOUT - 1));
        end else begin : g_off
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and a DMA.
// One outstanding transaction; a watchdog turns a hung access into an error.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,
    output logic          core_err,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_err,
    output logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    import mem_port_arbiter_pkg::*;

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          owner_q;
    logic          last_owner_q;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          any_req;
    logic          gnt;
    logic          in_idle;
    logic          in_access;
    logic          in_resp;
    logic          expired;
    logic          timed_out;

    assign any_req   = core_req | dma_req;
    assign gnt       = pick_owner(core_req, dma_req, last_owner_q);
    assign in_idle   = (state_q == ST_IDLE);
    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);
    // mem_ready takes priority over a coincident timeout
    assign timed_out = in_access & ~mem_ready & expired;

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (in_idle),
        .en      (in_access & ~mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (mem_ready || timed_out) state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q      <= OWN_CORE;
            last_owner_q <= OWN_DMA;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
        end else begin
            if (in_idle && any_req) begin
                owner_q   <= gnt;
                lat_we    <= (gnt == OWN_DMA) ? dma_we    : core_we;
                lat_addr  <= (gnt == OWN_DMA) ? dma_addr  : core_addr;
                lat_wdata <= (gnt == OWN_DMA) ? dma_wdata : core_wdata;
            end
            if (in_access && mem_ready) begin
                resp_rdata <= lat_we ? '0 : mem_rdata;
                resp_err   <= 1'b0;
            end else if (timed_out) begin
                resp_rdata <= '0;
                resp_err   <= 1'b1;
            end
            if (in_resp) begin
                last_owner_q <= owner_q;
            end
        end
    end

    assign core_ack   = in_resp & (owner_q == OWN_CORE);
    assign dma_ack    = in_resp & (owner_q == OWN_DMA);
    assign core_rdata = core_ack ? resp_rdata : '0;
    assign dma_rdata  = dma_ack  ? resp_rdata : '0;
    assign core_err   = core_ack & resp_err;
    assign dma_err    = dma_ack  & resp_err;

    assign mem_valid = in_access;
    assign mem_we    = in_access & lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-programmable memory model.
// Expected responses are queued at issue time and popped on each ack.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        own;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_ack, core_err;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dma_req, dma_we, dma_ack, dma_err;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_valid, mem_we, mem_ready, owner;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;
    int req_cyc = 0;
    int base = 0;

    int ready_delay = 0;
    logic stray = 1'b0;
    int acc_cnt = 0;
    int valid_len = 0;
    logic unstable = 1'b0;
    logic cap_we = 1'b0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;

    exp_t sb[$];

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata), .core_err(core_err),
        .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return a ^ 32'hDEADBEFF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory model: ready after ready_delay ACCESS cycles (-1 = never)
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                if (acc_cnt == 0) begin
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                    cap_we    = mem_we;
                    unstable  = 1'b0;
                end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
                             mem_we !== cap_we) begin
                    unstable = 1'b1;
                end
                mem_ready = (acc_cnt == ready_delay);
                mem_rdata = exp_rd(mem_addr);
                acc_cnt++;
                valid_len = acc_cnt;
            end else begin
                acc_cnt   = 0;
                mem_ready = stray;
                mem_rdata = 32'hBAD0BAD0;
            end
        end
    end

    always @(negedge clk) begin
        if (core_ack || dma_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
            chk("dual_ack", {31'b0, core_ack & dma_ack}, 32'd0);
            if (sb.size() == 0) begin
                chk("sb_depth", sb.size(), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("owner", {31'b0, dma_ack}, {31'b0, e.own});
                chk("rdata", dma_ack ? dma_rdata : core_rdata, e.rdata);
                chk("err", {31'b0, dma_ack ? dma_err : core_err}, {31'b0, e.err});
            end
        end
        if (!core_ack) chk("core_quiet", {31'b0, (|core_rdata) | core_err}, 32'd0);
        if (!dma_ack)  chk("dma_quiet",  {31'b0, (|dma_rdata) | dma_err}, 32'd0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic own, input logic [31:0] rd, input logic err);
        exp_t e;
        e.own = own;
        e.rdata = rd;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int target, input int budget);
        int n = 0;
        while (ack_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        chk("ack_wait", {31'b0, ack_cnt >= target}, 32'd1);
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, mem_valid}, 32'd0);
        chk({tag, "_we"},    {31'b0, mem_we}, 32'd0);
        chk({tag, "_addr"},  mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_owner"}, {31'b0, owner}, 32'd0);
        chk({tag, "_acks"},  {30'b0, core_ack, dma_ack}, 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk_quiet_outputs("rst");
        tick(2);
        reset = 1'b0;
    endtask

    task automatic core_txn(input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input logic err);
        base = ack_cnt;
        push(1'b0, rd, err);
        core_we = we;
        core_addr = a;
        core_wdata = wd;
        core_req = 1'b1;
        req_cyc = cyc;
        wait_ack(base + 1, 60);
        core_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        tick(1);
        apply_reset();
        tick(1);

        // 1: core read, ready in first ACCESS cycle; launch edge counts as edge 1
        ready_delay = 0;
        core_txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        chk("lat", ack_cyc - req_cyc + 1, 32'd3);
        tick(2);

        // 2: simultaneous requests after reset alternate C,D,C,D
        apply_reset();
        ready_delay = 1;
        core_addr = 32'h100; core_we = 0;
        dma_addr = 32'h200; dma_we = 0;
        push(1'b0, exp_rd(32'h100), 1'b0);
        push(1'b1, exp_rd(32'h200), 1'b0);
        push(1'b0, exp_rd(32'h100), 1'b0);
        push(1'b1, exp_rd(32'h200), 1'b0);
        base = ack_cnt;
        core_req = 1'b1;
        dma_req = 1'b1;
        wait_ack(base + 4, 80);
        core_req = 1'b0;
        dma_req = 1'b0;
        tick(4);
        chk("no_extra", ack_cnt, base + 4);

        // 3: DMA write, ready on fifth ACCESS cycle
        ready_delay = 4;
        base = ack_cnt;
        push(1'b1, 32'h0, 1'b0);
        dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h1234;
        dma_req = 1'b1;
        wait_ack(base + 1, 60);
        dma_req = 1'b0;
        chk("w_len", valid_len, 32'd5);
        chk("w_stable", {31'b0, unstable}, 32'd0);
        chk("w_we", {31'b0, cap_we}, 32'd1);
        chk("w_addr", cap_addr, 32'h40);
        chk("w_wdata", cap_wdata, 32'h1234);
        tick(2);

        // 4: watchdog fires after 16 cycles; ready on cycle 16 still wins
        ready_delay = -1;
        core_txn(1'b0, 32'h80, 32'h0, 32'h0, 1'b1);
        chk("to_len", valid_len, 32'd16);
        tick(2);
        ready_delay = 15;
        core_txn(1'b0, 32'h80, 32'h0, exp_rd(32'h80), 1'b0);
        chk("edge_len", valid_len, 32'd16);
        tick(2);

        // 5: reset in the second ACCESS cycle, held request re-served
        begin
            int n = 0;
            ready_delay = -1;
            core_we = 0; core_addr = 32'h30;
            core_req = 1'b1;
            while (acc_cnt < 2 && n < 20) begin
                tick(1);
                n++;
            end
            chk("mid_acc", acc_cnt, 32'd2);
            base = ack_cnt;
            reset = 1'b1;
            #1;
            chk_quiet_outputs("mid_rst");
            tick(3);
            chk("rst_noack", ack_cnt, base);
            ready_delay = 0;
            push(1'b0, exp_rd(32'h30), 1'b0);
            reset = 1'b0;
            wait_ack(base + 1, 20);
            core_req = 1'b0;
            tick(2);
        end

        // 6: stray mem_ready in IDLE and RESP is ignored
        stray = 1'b1;
        base = ack_cnt;
        tick(5);
        chk("stray_ack", ack_cnt, base);
        chk("stray_valid", {31'b0, mem_valid}, 32'd0);
        ready_delay = 2;
        core_txn(1'b0, 32'h14, 32'h0, exp_rd(32'h14), 1'b0);
        chk("stray_len", valid_len, 32'd3);
        tick(3);
        chk("stray_post", ack_cnt, base + 1);
        stray = 1'b0;

        chk("sb_left", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
